// File: rtl/data_memory_pipe.sv
// data_memory_pipe
// MEM-stage data memory for the pipelined datapath.
// After reset a CLEAR sequence writes zero to every word, one word per
// cycle, then `ready` rises and requests are accepted.
// Writes are masked by byte lane. Reads return after READ_LATENCY cycles
// with a one-cycle `read_valid` strobe.
// Out-of-range requests produce a one-cycle `addr_fault` pulse.
//
// Ports:
//   clk        - clock, rising-edge active
//   rst        - asynchronous active-high reset
//   address    - word address (ADDR_WIDTH bits)
//   data_write - store data
//   byte_en    - per-byte write enable, lane i = data_write[8i+7:8i]
//   memo_read  - read request
//   memo_write - write request
//   data_read  - read data; holds its value while read_valid=0
//   read_valid - one-cycle strobe per accepted read
//   addr_fault - one-cycle pulse for an out-of-range request
//   ready      - initialisation complete
module data_memory_pipe #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH_LOG2   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH-1:0]     data_write,
    input  logic [DATA_WIDTH/8-1:0]   byte_en,
    input  logic                      memo_read,
    input  logic                      memo_write,
    output logic [DATA_WIDTH-1:0]     data_read,
    output logic                      read_valid,
    output logic                      addr_fault,
    output logic                      ready
);

    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int N_LANES = DATA_WIDTH / 8;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [DEPTH_LOG2-1:0]   clear_ptr_r;
    logic [DEPTH_LOG2-1:0]   clear_ptr_next_s;
    logic                    ready_r;
    logic                    fault_r;

    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    in_range_s;
    logic [DEPTH_LOG2-1:0]   word_idx_s;
    logic                    rd_accept_s;
    logic                    wr_accept_s;
    logic                    fault_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;

    // Stage i of the read pipeline holds a read sampled i edges ago;
    // the last stage drives the outputs directly.
    logic [READ_LATENCY-1:0] v_pipe_r;
    logic [DATA_WIDTH-1:0]   d_pipe_r [READ_LATENCY];

    // Next-state logic for the initialisation FSM.
    always_comb begin
        state_next_s     = state_r;
        clear_ptr_next_s = clear_ptr_r;
        case (state_r)
            S_CLEAR: begin
                clear_ptr_next_s = clear_ptr_r + DEPTH_LOG2'(1);
                if (clear_ptr_r == {DEPTH_LOG2{1'b1}}) begin
                    state_next_s = S_READY;
                end else begin
                    state_next_s = S_CLEAR;
                end
            end
            S_READY: begin
                state_next_s = S_READY;
            end
            default: begin
                state_next_s     = S_CLEAR;
                clear_ptr_next_s = {DEPTH_LOG2{1'b0}};
            end
        endcase
    end

    // State register, clear pointer and the ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_CLEAR;
            clear_ptr_r <= {DEPTH_LOG2{1'b0}};
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            clear_ptr_r <= clear_ptr_next_s;
            ready_r     <= (state_next_s == S_READY);
        end
    end

    // Request decode. The shift-compare handles DEPTH_LOG2 == ADDR_WIDTH,
    // where every address is in range.
    always_comb begin
        in_range_s  = ((address >> DEPTH_LOG2) == {ADDR_WIDTH{1'b0}});
        word_idx_s  = address[DEPTH_LOG2-1:0];
        rd_accept_s = ready_r && memo_read;
        wr_accept_s = ready_r && memo_write && in_range_s;
        fault_s     = ready_r && (memo_read || memo_write) && !in_range_s;
        if (in_range_s) begin
            rd_data_s = mem_r[word_idx_s];
        end else begin
            rd_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Memory array: zero-fill during CLEAR, byte-masked store when ready.
    // Reads capture the array before this edge's write (read-first).
    always_ff @(posedge clk) begin
        if (state_r == S_CLEAR) begin
            mem_r[clear_ptr_r] <= {DATA_WIDTH{1'b0}};
        end else if (wr_accept_s) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (byte_en[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= data_write[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline. Data stages load only alongside a valid read, so
    // the final stage holds the last returned word between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_pipe_r <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                d_pipe_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            v_pipe_r[0] <= rd_accept_s;
            if (rd_accept_s) begin
                d_pipe_r[0] <= rd_data_s;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                v_pipe_r[i] <= v_pipe_r[i-1];
                if (v_pipe_r[i-1]) begin
                    d_pipe_r[i] <= d_pipe_r[i-1];
                end
            end
        end
    end

    // Address fault pulse: one per faulting cycle, even with read and write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_s;
        end
    end

    assign data_read  = d_pipe_r[READ_LATENCY-1];
    assign read_valid = v_pipe_r[READ_LATENCY-1];
    assign addr_fault = fault_r;
    assign ready      = ready_r;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Scoreboard bench for data_memory_pipe.
// Two instances, READ_LATENCY 1 and 3, both with DEPTH_LOG2 = 4, share one
// stimulus stream. A reference memory model predicts each read and pushes
// {data, due edge} into a per-instance queue. A negedge monitor pops an
// entry on every read_valid and also checks ready, addr_fault and the
// data_read hold behaviour.
module tb_data_memory_pipe;

    localparam int DEPTH = 16;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [15:0] data_write = 16'h0000;
    logic [1:0]  byte_en = 2'b00;
    logic        memo_read = 1'b0;
    logic        memo_write = 1'b0;

    logic [15:0] dr [2];
    logic        rv [2];
    logic        af [2];
    logic        rdy [2];

    exp_t        exp_q [2][$];
    bit          fault_exp [int];
    logic [15:0] last_data [2];
    logic [15:0] mem_m [DEPTH];

    int edge_cnt  = 0;
    int since_rel = 0;
    int n_checks  = 0;
    int n_fail    = 0;

    data_memory_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(4), .READ_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .address(address), .data_write(data_write),
        .byte_en(byte_en), .memo_read(memo_read), .memo_write(memo_write),
        .data_read(dr[0]), .read_valid(rv[0]), .addr_fault(af[0]), .ready(rdy[0])
    );

    data_memory_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_LOG2(4), .READ_LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .address(address), .data_write(data_write),
        .byte_en(byte_en), .memo_read(memo_read), .memo_write(memo_write),
        .data_read(dr[1]), .read_valid(rv[1]), .addr_fault(af[1]), .ready(rdy[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) since_rel <= 0;
        else     since_rel <= since_rel + 1;
    end

    function automatic void chk(input string name, input int j,
                                input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (latency-%0d dut) at edge %0d: got %h, expected %h",
                     name, (j == 0) ? 1 : 3, edge_cnt, act, req);
        end
    endfunction

    // Monitor: compares every output of both instances after each edge.
    always @(negedge clk) begin
        exp_t e;
        for (int j = 0; j < 2; j++) begin
            chk("ready", j, {31'd0, rdy[j]}, {31'd0, (!rst && since_rel >= DEPTH)});
            chk("addr_fault", j, {31'd0, af[j]}, {31'd0, (!rst && fault_exp.exists(edge_cnt))});
            if (rv[j] === 1'b1) begin
                if (exp_q[j].size() == 0) begin
                    chk("unexpected_read_valid", j, 32'd1, 32'd0);
                end else begin
                    e = exp_q[j].pop_front();
                    chk("read_latency", j, edge_cnt, e.due);
                    chk("read_data", j, {16'd0, dr[j]}, {16'd0, e.data});
                    last_data[j] = e.data;
                end
            end else begin
                chk("read_valid_low", j, {31'd0, rv[j]}, 32'd0);
                chk("data_hold", j, {16'd0, dr[j]}, {16'd0, last_data[j]});
                if (exp_q[j].size() > 0 && exp_q[j][0].due <= edge_cnt) begin
                    e = exp_q[j].pop_front();
                    chk("missing_read_valid", j, 32'd0, 32'd1);
                end
            end
        end
    end

    // One request cycle: drive inputs after the monitor, predict responses.
    task automatic op(input logic rd, input logic wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic [1:0] be);
        int   k;
        logic inr;
        exp_t e;
        @(negedge clk);
        #1;
        memo_read  = rd;
        memo_write = wr;
        address    = a;
        data_write = wd;
        byte_en    = be;
        k = edge_cnt + 1;
        if (since_rel >= DEPTH) begin
            inr = (a < 16'(DEPTH));
            if (rd) begin
                e.data = inr ? mem_m[a[3:0]] : 16'h0000;
                e.due  = k;
                exp_q[0].push_back(e);
                e.due  = k + 2;
                exp_q[1].push_back(e);
            end
            if ((rd || wr) && !inr) fault_exp[k] = 1'b1;
            if (wr && inr) begin
                for (int b = 0; b < 2; b++)
                    if (be[b]) mem_m[a[3:0]][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    endtask

    task automatic rand_ops(input int n);
        for (int i = 0; i < n; i++)
            op(1'($urandom), 1'($urandom), 16'($urandom_range(0, 21)),
               16'($urandom), 2'($urandom));
    endtask

    // Assert reset between edges; in-flight reads and faults are discarded.
    task automatic do_reset(input int hold_edges);
        @(negedge clk);
        #2;
        rst = 1'b1;
        memo_read  = 1'b0;
        memo_write = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        fault_exp.delete();
        last_data[0] = 16'h0000;
        last_data[1] = 16'h0000;
        for (int w = 0; w < DEPTH; w++) mem_m[w] = 16'h0000;
        repeat (hold_edges) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        last_data[0] = 16'h0000;
        last_data[1] = 16'h0000;
        for (int w = 0; w < DEPTH; w++) mem_m[w] = 16'h0000;
        do_reset(3);

        // Requests during CLEAR must be ignored.
        rand_ops(DEPTH);
        op(1'b1, 1'b0, 16'h0005, 16'h0000, 2'b00);

        // Full write then read-back, then byte-lane merges.
        op(1'b0, 1'b1, 16'h0003, 16'hA5C3, 2'b11);
        op(1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00);
        op(1'b0, 1'b1, 16'h0003, 16'h1234, 2'b01);
        op(1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00);
        op(1'b0, 1'b1, 16'h0003, 16'hFF00, 2'b10);
        op(1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00);
        op(1'b0, 1'b1, 16'h0003, 16'h0000, 2'b00);

        // Back-to-back pipelined reads.
        for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 16'(i), 16'h0010 + 16'(i), 2'b11);
        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 16'(i), 16'h0000, 2'b00);

        // Same-cycle read and write: read-first, then new data.
        op(1'b0, 1'b1, 16'h0007, 16'h0001, 2'b11);
        op(1'b1, 1'b1, 16'h0007, 16'h0002, 2'b11);
        op(1'b1, 1'b0, 16'h0007, 16'h0000, 2'b00);

        // Out of range: write, read, and both together.
        op(1'b0, 1'b1, 16'h0010, 16'hDEAD, 2'b11);
        op(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00);
        op(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);
        op(1'b1, 1'b1, 16'h8001, 16'hBEEF, 2'b11);
        idle(4);

        rand_ops(400);

        // Reset with a latency-3 read in flight.
        op(1'b1, 1'b0, 16'h0007, 16'h0000, 2'b00);
        do_reset(2);
        rand_ops(DEPTH);
        rand_ops(200);
        idle(5);

        n_checks++;
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d reads still pending, expected 0/0",
                     exp_q[0].size(), exp_q[1].size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
Parametrised successor to the single-cycle datapath's data memory, used in the pipelined datapath's MEM stage. It provides per-byte write enables and a configurable registered read latency with a valid strobe. It flags out-of-range addresses. After reset it runs a hardware zero-initialisation sequence and signals readiness.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 16, width of the address port.
DEPTH_LOG2, 8, log2 of the number of words (DEPTH = 2**DEPTH_LOG2); must be <= ADDR_WIDTH.
READ_LATENCY, 1, cycles from read request to read_valid; legal range 1..4.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
address  input  ADDR_WIDTH  word address
data_write  input  DATA_WIDTH  store data
byte_en  input  DATA_WIDTH/8  per-byte write enable, lane i = data_write[8i+7:8i]
memo_read  input  1  read request, sampled each rising edge
memo_write  input  1  write request, sampled each rising edge
data_read  output  DATA_WIDTH  read data, meaningful when read_valid=1
read_valid  output  1  one-cycle strobe for each accepted read
addr_fault  output  1  one-cycle pulse for an out-of-range request
ready  output  1  1 = initialisation done, requests accepted

Behaviour:
- Reset (async, rst=1):
  - Outputs: data_read=0, read_valid=0, addr_fault=0, ready=0.
  - The read pipeline is flushed.
  - FSM enters CLEAR with clear_ptr=0.
  - Memory array contents are not reset directly; they are zeroed by CLEAR.
- FSM states: CLEAR, READY.
  - CLEAR: each edge writes 0 to word clear_ptr, then increments clear_ptr.
  - The edge that writes word DEPTH-1 moves the FSM to READY; ready=1 from the following cycle.
  - CLEAR therefore lasts DEPTH cycles after reset deassertion.
  - READY is held until the next reset.
  - Reset asserted during CLEAR restarts the sequence from clear_ptr=0.
- While ready=0, memo_read, memo_write and address are ignored. No write, no read_valid, no addr_fault.
- Range check:
  - In range: address < DEPTH, i.e. address[ADDR_WIDTH-1:DEPTH_LOG2]==0.
  - Word index = address[DEPTH_LOG2-1:0].
- Write (ready=1, memo_write=1, in range):
  - At the sampling edge, each lane with byte_en[i]=1 is updated; other lanes are unchanged.
  - byte_en=0 is a legal no-op.
- Read (ready=1, memo_read=1):
  - Request sampled at edge k; read_valid=1 and data_read valid for exactly the one cycle following edge k+READ_LATENCY-1.
  - Back-to-back reads are fully pipelined at one per cycle, returned in order. There is no stall.
  - data_read holds its last value while read_valid=0.
- Collisions:
  - Read and write to the same word in the same cycle: read-first, returns the pre-write data.
  - Write at edge k followed by a read sampled at edge k+1 returns the new data.
  - memo_read and memo_write both 1 is legal: both are performed.
- Out-of-range request:
  - No array write.
  - addr_fault=1 for one cycle following the sampling edge.
  - A read still produces its read_valid slot with data_read=0.
  - Read and write both out of range in the same cycle give a single addr_fault pulse.
- Reset mid-read: in-flight reads are discarded; no read_valid after rst deasserts.

Test Plan:
- DEPTH_LOG2=4: release rst -> ready=0 for 16 cycles, then 1. Requests issued during CLEAR produce no read_valid and no addr_fault. A read of addr 5 afterwards returns 16'h0000.
- READY, READ_LATENCY=1: write addr 3 data 16'hA5C3 byte_en=2'b11, next cycle read addr 3 -> read_valid 1 cycle later, data_read=16'hA5C3.
- Byte lanes: addr 3 holds 16'hA5C3; write 16'h1234 byte_en=2'b01, then read -> 16'hA534. Write byte_en=2'b10 16'hFF00, then read -> 16'hFF34.
- READ_LATENCY=3: reads of addr 0,1,2 on consecutive cycles (contents 16'h0010, 16'h0011, 16'h0012) -> read_valid high 3 consecutive cycles starting 3 cycles after the first request, data in order.
- Same-cycle read+write addr 7 (old 16'h0001, new 16'h0002) -> data_read=16'h0001. Read of addr 7 on the next cycle -> 16'h0002.
- DEPTH_LOG2=4: write addr 16'h0010 -> addr_fault pulse, addr 0 unchanged. Read addr 16'h0020 -> addr_fault pulse, read_valid with data_read=0. Assert rst during an in-flight READ_LATENCY=3 read -> no read_valid, and ready stays 0 for 16 cycles after rst deasserts.
